// File: rtl/ahb_slave_mem.sv
// AHB slave word memory with programmable wait states, byte-lane writes and two-cycle ERROR responses.
// Optional RETRY responses are enabled by defining AHB_SLV_RETRY_EN.
module ahb_slave_mem #(
   parameter int WDT         = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic           i_hclk,
   input  logic           i_hreset,
   input  logic           i_hsel,
   input  logic           i_hready,
   input  logic [31:0]    i_haddr,
   input  logic [1:0]     i_htrans,
   input  logic           i_hwrite,
   input  logic [1:0]     i_hsize,
   input  logic [WDT-1:0] i_hwdata,
   input  logic           i_retry_req,
   output logic           o_hready,
   output logic [1:0]     o_hresp,
   output logic [WDT-1:0] o_hrdata
);

   localparam int LANES = WDT / 8;
   localparam int LB    = $clog2(LANES);
   localparam int AW    = $clog2(DEPTH);

   localparam logic [1:0] RESP_OKAY  = 2'd0;
   localparam logic [1:0] RESP_ERROR = 2'd1;
   localparam logic [1:0] RESP_RETRY = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t           r_state;
   logic [3:0]       r_wait;
   logic             r_write;
   logic [AW-1:0]    r_idx;
   logic [LANES-1:0] r_mask;
   logic             r_hready;
   logic [1:0]       r_hresp;
   logic [WDT-1:0]   r_hrdata;
   logic [WDT-1:0]   r_mem [DEPTH];

   logic             w_accept;
   logic [7:0]       w_base;
   logic [2:0]       w_amask;
   logic [LANES-1:0] w_mask;
   logic             w_err;
   logic             w_retry;
   logic [AW-1:0]    w_acc_idx;
   logic             w_wr_commit;
   logic             w_rd_load;
   logic [AW-1:0]    w_rd_idx;
   logic [WDT-1:0]   w_rd_word;
   logic [WDT-1:0]   w_rd_merged;
   logic             w_unused;

   // Only states that are driving hready high can take a new address phase.
   assign w_accept = i_hsel & i_hready & i_htrans[1] & r_hready;

   always_comb begin
      w_base  = 8'h01;
      w_amask = 3'b000;
      case (i_hsize)
         2'd0:    begin w_base = 8'h01; w_amask = 3'b000; end
         2'd1:    begin w_base = 8'h03; w_amask = 3'b001; end
         2'd2:    begin w_base = 8'h0F; w_amask = 3'b011; end
         default: begin w_base = 8'hFF; w_amask = 3'b111; end
      endcase
   end

   assign w_mask    = LANES'(w_base) << i_haddr[LB-1:0];
   assign w_acc_idx = i_haddr[LB+AW-1:LB];
   assign w_err     = ((WDT == 32) && (i_hsize == 2'd3))
                    | (|(i_haddr[2:0] & w_amask))
                    | (|i_haddr[31:LB+AW]);

`ifdef AHB_SLV_RETRY_EN
   assign w_retry  = i_retry_req & ~w_err;
   assign w_unused = i_htrans[0];
`else
   assign w_retry  = 1'b0;
   assign w_unused = i_htrans[0] ^ i_retry_req;
`endif

   assign w_wr_commit = (r_state == S_DATA) & r_write & ~i_hreset;

   // Read data is captured on the edge that enters DATA: the accept edge without wait states, else the last WAIT edge.
   assign w_rd_load = (w_accept & ~w_err & ~w_retry & ~i_hwrite & (WAIT_STATES == 0))
                    | ((r_state == S_WAIT) & (r_wait == 4'd1) & ~r_write);
   assign w_rd_idx  = (r_state == S_WAIT) ? r_idx : w_acc_idx;
   assign w_rd_word = r_mem[w_rd_idx];

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_bypass
         assign w_rd_merged[gi*8 +: 8] = (w_wr_commit && r_mask[gi] && (r_idx == w_rd_idx))
                                       ? i_hwdata[gi*8 +: 8] : w_rd_word[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge i_hclk) begin
      if (w_wr_commit) begin
         for (int l = 0; l < LANES; l++) begin
            if (r_mask[l]) r_mem[r_idx][l*8 +: 8] <= i_hwdata[l*8 +: 8];
         end
      end
   end

   always_ff @(posedge i_hclk or posedge i_hreset) begin
      if (i_hreset) begin
         r_state  <= S_IDLE;
         r_wait   <= 4'd0;
         r_write  <= 1'b0;
         r_idx    <= '0;
         r_mask   <= '0;
         r_hready <= 1'b1;
         r_hresp  <= RESP_OKAY;
         r_hrdata <= '0;
      end else begin
         if (w_rd_load) r_hrdata <= w_rd_merged;
         if (w_accept) begin
            r_write <= i_hwrite;
            r_idx   <= w_acc_idx;
            r_mask  <= w_mask;
            if (w_err | w_retry) begin
               r_state  <= S_ERR1;
               r_hready <= 1'b0;
               r_hresp  <= w_err ? RESP_ERROR : RESP_RETRY;
            end else if (WAIT_STATES > 0) begin
               r_state  <= S_WAIT;
               r_hready <= 1'b0;
               r_hresp  <= RESP_OKAY;
               r_wait   <= 4'(WAIT_STATES);
            end else begin
               r_state  <= S_DATA;
               r_hready <= 1'b1;
               r_hresp  <= RESP_OKAY;
            end
         end else begin
            case (r_state)
               S_WAIT: begin
                  if (r_wait == 4'd1) begin
                     r_state  <= S_DATA;
                     r_hready <= 1'b1;
                     r_wait   <= 4'd0;
                  end else begin
                     r_wait <= r_wait - 4'd1;
                  end
               end
               S_ERR1: begin
                  r_state  <= S_ERR2;
                  r_hready <= 1'b1;
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_hready <= 1'b1;
                  r_hresp  <= RESP_OKAY;
               end
            endcase
         end
      end
   end

   assign o_hready = r_hready;
   assign o_hresp  = r_hresp;
   assign o_hrdata = r_hrdata;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances (0, 2 and 3 wait states) share one bus,
// only the instance chosen by sel is selected and drives the bus HREADY.
module tb_ahb_slave_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel;
   int          sel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [1:0]  hsize;
   logic [31:0] hwdata;
   logic        rr;
   logic        bus_hready;

   logic        rdy_a, rdy_b, rdy_c;
   logic [1:0]  resp_a, resp_b, resp_c;
   logic [31:0] rdata_a, rdata_b, rdata_c;
   logic        cur_ready;
   logic [1:0]  cur_resp;
   logic [31:0] cur_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   always_comb begin
      cur_ready = rdy_a;
      cur_resp  = resp_a;
      cur_rdata = rdata_a;
      case (sel)
         1: begin cur_ready = rdy_b; cur_resp = resp_b; cur_rdata = rdata_b; end
         2: begin cur_ready = rdy_c; cur_resp = resp_c; cur_rdata = rdata_c; end
         default: ;
      endcase
   end
   assign bus_hready = cur_ready;

   ahb_slave_mem #(.WDT(32), .DEPTH(256), .WAIT_STATES(0)) u_dut_a (
      .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel && sel == 0), .i_hready(bus_hready),
      .i_haddr(haddr), .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize),
      .i_hwdata(hwdata), .i_retry_req(rr),
      .o_hready(rdy_a), .o_hresp(resp_a), .o_hrdata(rdata_a));

   ahb_slave_mem #(.WDT(32), .DEPTH(256), .WAIT_STATES(2)) u_dut_b (
      .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel && sel == 1), .i_hready(bus_hready),
      .i_haddr(haddr), .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize),
      .i_hwdata(hwdata), .i_retry_req(rr),
      .o_hready(rdy_b), .o_hresp(resp_b), .o_hrdata(rdata_b));

   ahb_slave_mem #(.WDT(32), .DEPTH(256), .WAIT_STATES(3)) u_dut_c (
      .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel && sel == 2), .i_hready(bus_hready),
      .i_haddr(haddr), .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize),
      .i_hwdata(hwdata), .i_retry_req(rr),
      .o_hready(rdy_c), .o_hresp(resp_c), .o_hrdata(rdata_c));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transfer: address phase, then data phase until hready, then the completing edge.
   task automatic xfer(input int s, input logic [31:0] addr, input logic wr, input logic [1:0] size,
                       input logic [31:0] wdata, input logic retry,
                       output int waits, output logic [1:0] r0, output logic [1:0] r1,
                       output logic [31:0] rd);
      sel    = s;
      hsel   = 1'b1;
      haddr  = addr;
      htrans = 2'd2;
      hwrite = wr;
      hsize  = size;
      rr     = retry;
      step();
      hsel   = 1'b0;
      htrans = 2'd0;
      hwrite = 1'b0;
      rr     = 1'b0;
      hwdata = wdata;
      r0     = cur_resp;
      waits  = 0;
      while (cur_ready !== 1'b1 && waits < 20) begin
         waits++;
         step();
      end
      r1 = cur_resp;
      rd = cur_rdata;
      step();
      $display("xfer dut=%0d addr=%h wr=%0d size=%0d wdata=%h retry=%0d waits=%0d resp=%0d/%0d rdata=%h",
               s, addr, wr, size, wdata, retry, waits, r0, r1, rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      logic [1:0]  r0, r1;
      logic [31:0] rd;

      rst = 1'b1; sel = 0; hsel = 1'b0; haddr = '0; htrans = 2'd0;
      hwrite = 1'b0; hsize = 2'd0; hwdata = '0; rr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_hready_a", 32'(rdy_a), 32'd1);
      check_eq("rst_hresp_a", 32'(resp_a), 32'd0);
      check_eq("rst_hrdata_a", rdata_a, 32'd0);
      check_eq("rst_hready_c", 32'(rdy_c), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Write then read of the same word back-to-back: read data comes from the bypass path.
      sel = 0; hsel = 1'b1; haddr = 32'h10; htrans = 2'd2; hwrite = 1'b1; hsize = 2'd2;
      step();
      check_eq("bp_wr_hready", 32'(cur_ready), 32'd1);
      hwdata = 32'hDEADBEEF; haddr = 32'h10; htrans = 2'd2; hwrite = 1'b0;
      step();
      check_eq("bp_rd_hready", 32'(cur_ready), 32'd1);
      check_eq("bp_rd_hresp", 32'(cur_resp), 32'd0);
      check_eq("bp_rd_data", cur_rdata, 32'hDEADBEEF);
      hsel = 1'b0; htrans = 2'd0;
      step();
      $display("xfer dut=0 pipelined write/read 0x10 rdata=%h", rdata_a);

      // Byte and halfword lane masking.
      xfer(0, 32'h10, 1'b1, 2'd2, 32'h11223344, 1'b0, w, r0, r1, rd);
      check_eq("w_word_waits", 32'(w), 32'd0);
      check_eq("w_word_resp", 32'(r1), 32'd0);
      xfer(0, 32'h13, 1'b1, 2'd0, 32'hAAAAAAAA, 1'b0, w, r0, r1, rd);
      check_eq("w_byte_resp", 32'(r1), 32'd0);
      xfer(0, 32'h10, 1'b0, 2'd2, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("rd_byte_merge", rd, 32'hAA223344);
      xfer(0, 32'h11, 1'b1, 2'd1, 32'h55555555, 1'b0, w, r0, r1, rd);
      check_eq("misal_half_waits", 32'(w), 32'd1);
      check_eq("misal_half_resp0", 32'(r0), 32'd1);
      check_eq("misal_half_resp1", 32'(r1), 32'd1);
      xfer(0, 32'h10, 1'b0, 2'd2, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("rd_after_err", rd, 32'hAA223344);
      xfer(0, 32'h12, 1'b1, 2'd1, 32'h12345678, 1'b0, w, r0, r1, rd);
      check_eq("w_half_resp", 32'(r1), 32'd0);
      xfer(0, 32'h10, 1'b0, 2'd2, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("rd_half_merge", rd, 32'h12343344);

      // Error responses: out of range, dword on a 32-bit bus, misaligned word.
      xfer(0, 32'h400, 1'b0, 2'd2, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("range_waits", 32'(w), 32'd1);
      check_eq("range_resp0", 32'(r0), 32'd1);
      check_eq("range_resp1", 32'(r1), 32'd1);
      xfer(0, 32'h0, 1'b0, 2'd3, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("dword_waits", 32'(w), 32'd1);
      check_eq("dword_resp0", 32'(r0), 32'd1);
      check_eq("dword_resp1", 32'(r1), 32'd1);
      xfer(0, 32'h2, 1'b0, 2'd2, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("misal_word_resp", 32'(r1), 32'd1);

      // IDLE/BUSY on the wait-state instance: zero-wait OKAY.
      sel = 1; hsel = 1'b1; haddr = 32'h20; htrans = 2'd1; hwrite = 1'b0; hsize = 2'd2;
      step();
      check_eq("busy_hready", 32'(cur_ready), 32'd1);
      check_eq("busy_hresp", 32'(cur_resp), 32'd0);
      htrans = 2'd0;
      step();
      check_eq("idle_hready", 32'(cur_ready), 32'd1);
      hsel = 1'b0;
      $display("xfer dut=1 busy/idle hready=%0d", cur_ready);

      // Two wait states.
      xfer(1, 32'h20, 1'b1, 2'd2, 32'hCAFEF00D, 1'b0, w, r0, r1, rd);
      check_eq("ws2_wr_waits", 32'(w), 32'd2);
      xfer(1, 32'h20, 1'b0, 2'd2, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("ws2_rd_waits", 32'(w), 32'd2);
      check_eq("ws2_rd_resp0", 32'(r0), 32'd0);
      check_eq("ws2_rd_resp1", 32'(r1), 32'd0);
      check_eq("ws2_rd_data", rd, 32'hCAFEF00D);

      // Reset in the middle of a wait-state write drops it.
      xfer(2, 32'h30, 1'b1, 2'd2, 32'h01020304, 1'b0, w, r0, r1, rd);
      check_eq("ws3_wr_waits", 32'(w), 32'd3);
      sel = 2; hsel = 1'b1; haddr = 32'h30; htrans = 2'd2; hwrite = 1'b1; hsize = 2'd2;
      step();
      hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = 32'hFFFFFFFF;
      check_eq("ws3_wait_hready", 32'(cur_ready), 32'd0);
      step();
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_hready", 32'(cur_ready), 32'd1);
      check_eq("async_rst_hresp", 32'(cur_resp), 32'd0);
      $display("xfer dut=2 write 0x30 aborted by reset");
      @(negedge clk);
      rst = 1'b0;
      step();
      xfer(2, 32'h30, 1'b0, 2'd2, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("rst_no_commit", rd, 32'h01020304);

      // Retry request handling.
      xfer(0, 32'h40, 1'b1, 2'd2, 32'h11111111, 1'b0, w, r0, r1, rd);
      check_eq("pre_retry_resp", 32'(r1), 32'd0);
      xfer(0, 32'h40, 1'b1, 2'd2, 32'h22222222, 1'b1, w, r0, r1, rd);
`ifdef AHB_SLV_RETRY_EN
      check_eq("retry_waits", 32'(w), 32'd1);
      check_eq("retry_resp0", 32'(r0), 32'd2);
      check_eq("retry_resp1", 32'(r1), 32'd2);
      xfer(0, 32'h40, 1'b0, 2'd2, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("retry_no_write", rd, 32'h11111111);
      xfer(0, 32'h40, 1'b1, 2'd2, 32'h22222222, 1'b0, w, r0, r1, rd);
      check_eq("reissue_resp", 32'(r1), 32'd0);
`else
      check_eq("noretry_waits", 32'(w), 32'd0);
      check_eq("noretry_resp", 32'(r1), 32'd0);
`endif
      xfer(0, 32'h40, 1'b0, 2'd2, 32'h0, 1'b0, w, r0, r1, rd);
      check_eq("final_0x40", rd, 32'h22222222);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
